// File: rtl/uart_rx_if.sv
// Bundle of the UART receive path signals between the RX pin / CPU side and the receiver.
// Ports: rx (serial line), rd (consumer acknowledge) toward the receiver; data, valid, frame_err, overrun, busy back.
// slave modport is the receiver itself; master modport is the line driver plus consumer.
interface uart_rx_if #(
  parameter int WIDTH = 8
);
  logic             rx;
  logic             rd;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output rx, rd,
    input  data, valid, frame_err, overrun, busy
  );

  modport slave (
    input  rx, rd,
    output data, valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Serial-to-parallel UART receiver: idle-high line, WIDTH data bits LSB first sampled mid-bit, one stop bit.
// Latency: valid/frame_err update on the stop-bit sample edge, 2 + HALF + (WIDTH+1)*CLKS_PER_BIT edges after the start bit reaches sync flop 1.
// Backpressure: none on the line; a good frame arriving while valid is still set is dropped and flagged as overrun.
// Ports: clk, rst (async active-high), bus (uart_rx_if.slave: rx, rd in; data, valid, frame_err, overrun, busy out).
module uart_rx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    sync1_d = bus.rx;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Acknowledge clears the status; a same-edge frame result below overrides it.
    if (bus.rd) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;   // glitch shorter than half a bit
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d              = '0;
          shift_d            = shift_q >> 1;
          shift_d[WIDTH-1]   = rx_s;   // LSB arrives first and ends up at bit 0
          if (bit_q == LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            if (!valid_q || bus.rd) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        // Hold here until the line idles so a held-low line is not seen as new start bits.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames with a byte scoreboard checked by a monitor process.
module tb_uart_rx;

  localparam int CPB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.WIDTH(8)) bus ();

  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests      = 0;
  int         fails      = 0;
  int         n_valid_ev = 0;
  int         n_ferr_ev  = 0;
  int         ev_target  = 0;
  int         start_cyc  = 0;
  int         last_ev_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reports each newly presented byte (valid rising, or a fresh byte while valid) against the queue.
  task automatic monitor_loop();
    logic       pv = 1'b0;
    logic       pf = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.valid && (!pv || bus.data != pd)) begin
        n_valid_ev++;
        last_ev_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, bus.data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", {24'h0, bus.data}, {24'h0, e});
        end
      end
      if (bus.frame_err && !pf) n_ferr_ev++;
      pv = bus.valid;
      pf = bus.frame_err;
      pd = bus.data;
    end
  endtask

  task automatic drive(logic v, int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [7:0] b, logic stop, logic push);
    if (push) begin
      exp_q.push_back(b);
      ev_target++;
    end
    start_cyc = cyc + 1;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, CPB);
  endtask

  task automatic wait_ev(string name);
    int t = 0;
    while (n_valid_ev < ev_target && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, (n_valid_ev >= ev_target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic pulse_rd();
    bus.rd = 1'b1;
    @(posedge clk);
    #1;
    bus.rd = 1'b0;
  endtask

  task automatic rd_consumer(int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!bus.valid && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("b2b_valid_seen", {31'h0, bus.valid}, 32'd1);
      check("b2b_no_overrun", {31'h0, bus.overrun}, 32'd0);
      pulse_rd();
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.rd = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'h0, bus.data}, 32'h0);
    check("rst_valid", {31'h0, bus.valid}, 32'd0);
    check("rst_ferr", {31'h0, bus.frame_err}, 32'd0);
    check("rst_overrun", {31'h0, bus.overrun}, 32'd0);
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 4);

    // Single frame 0x05 and its latency
    send_frame(8'h05, 1'b1, 1'b1);
    drive(1'b1, 4);
    wait_ev("wait_05");
    check("latency_05", last_ev_cyc - start_cyc, 32'd21);
    check("flags_05_ferr", {31'h0, bus.frame_err}, 32'd0);
    check("flags_05_ovr", {31'h0, bus.overrun}, 32'd0);
    check("idle_busy_05", {31'h0, bus.busy}, 32'd0);
    pulse_rd();
    check("rd_clears_valid", {31'h0, bus.valid}, 32'd0);
    check("rd_keeps_data", {24'h0, bus.data}, 32'h05);

    // Back-to-back 0x00..0x06 with a consumer acknowledging each byte
    fork
      begin
        for (int b = 0; b < 7; b++) send_frame(8'(b), 1'b1, 1'b1);
        drive(1'b1, 4);
      end
      rd_consumer(7);
    join
    wait_ev("wait_b2b");
    check("b2b_count", n_valid_ev, 32'd8);

    // Overrun: 0xA5 left unread, 0x3C dropped
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 6);
    wait_ev("wait_a5");
    check("ovr_data", {24'h0, bus.data}, 32'hA5);
    check("ovr_valid", {31'h0, bus.valid}, 32'd1);
    check("ovr_flag", {31'h0, bus.overrun}, 32'd1);
    pulse_rd();
    check("ovr_rd_valid", {31'h0, bus.valid}, 32'd0);
    check("ovr_rd_flag", {31'h0, bus.overrun}, 32'd0);

    // Framing error with a held-low line
    send_frame(8'h81, 1'b0, 1'b0);
    drive(1'b0, 10 * CPB);
    check("ferr_flag", {31'h0, bus.frame_err}, 32'd1);
    check("ferr_valid", {31'h0, bus.valid}, 32'd0);
    check("ferr_busy_held", {31'h0, bus.busy}, 32'd1);
    check("ferr_events", n_ferr_ev, 32'd1);
    drive(1'b1, 4);
    check("ferr_busy_released", {31'h0, bus.busy}, 32'd0);
    pulse_rd();
    check("ferr_rd_clear", {31'h0, bus.frame_err}, 32'd0);

    // One-cycle glitch while idle
    drive(1'b0, 1);
    drive(1'b1, 10);
    check("glitch_no_byte", n_valid_ev, 32'd9);
    check("glitch_valid", {31'h0, bus.valid}, 32'd0);
    check("glitch_ferr", {31'h0, bus.frame_err}, 32'd0);
    check("glitch_busy", {31'h0, bus.busy}, 32'd0);

    // Frame after the break is received normally, left unread
    send_frame(8'h42, 1'b1, 1'b1);
    drive(1'b1, 4);
    wait_ev("wait_42");
    check("post_break_ferr", {31'h0, bus.frame_err}, 32'd0);

    // Reset during data bit 4 of a frame
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    bus.rx = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_busy", {31'h0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", {24'h0, bus.data}, 32'h0);
    check("mid_rst_valid", {31'h0, bus.valid}, 32'd0);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
    check("mid_rst_flags", {30'h0, bus.frame_err, bus.overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 4);
    send_frame(8'h7E, 1'b1, 1'b1);
    drive(1'b1, 4);
    wait_ev("wait_7e");
    check("post_rst_flags", {30'h0, bus.frame_err, bus.overrun}, 32'd0);
    pulse_rd();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
